rvvi_trace_collector: RTL and testbench
=======================================

Name: rvvi_trace_collector

Overview:
- Reader end of the RVVI trace: samples one hart's retirement slots on every clk and turns them into a stream of compact retirement records.
- Checks `order` continuity and single-GPR-writeback rules.
- Buffers records in a multi-write, single-read FIFO.
- Drains records over a valid/ready port to the host-side comparator/transactor.

Parameters:
- RETIRE, 2, retirement slots per cycle (legal 1..2)
- XLEN, 32, GPR/PC width
- ILEN, 32, instruction width
- DEPTH, 16, FIFO entries (power of two, >= 2*RETIRE)

Ports:
- clk  in  1  interface clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  RETIRE  per-slot retired flag
- in_order  in  RETIRE*64  per-slot order count
- in_insn  in  RETIRE*ILEN  instruction bits
- in_trap  in  RETIRE  trapped
- in_halt  in  RETIRE  halted
- in_mode  in  RETIRE*2  privilege mode
- in_pc_rdata  in  RETIRE*XLEN  PC of insn
- in_pc_wdata  in  RETIRE*XLEN  next PC
- in_x_wb  in  RETIRE*32  GPR writeback flags
- in_x_wdata  in  RETIRE*32*XLEN  GPR values
- out_valid  out  1  record available
- out_ready  in  1  consumer accepts
- out_rec  out  rvvi_rec_t  head record
- overflow  out  1  sticky, a record was dropped
- order_err  out  1  sticky, order discontinuity
- multi_wb_err  out  1  sticky, more than one GPR written in one slot
- drop_cnt  out  16  dropped records, saturating
- ret_cnt  out  32  accepted records, wrapping

Behaviour:
- Reset (sync, high) clears everything: out_valid=0, out_rec=0, all sticky flags=0, drop_cnt=0, ret_cnt=0. FIFO is emptied and the "expected order" state is set invalid. Reset wins over any same-cycle input or handshake.
- Record build (combinational per slot):
  - Fields: order, insn, pc_rdata, pc_wdata, trap, halt, mode.
  - x_idx = lowest set bit of in_x_wb[31:1]; bit 0 (x0) is ignored.
  - x_valid = any bit in [31:1] set; x_data = in_x_wdata[x_idx].
  - Two or more bits set in [31:1] sets multi_wb_err. The lowest index is still reported.
- Enqueue:
  - Valid slots are compacted in ascending slot order and written to consecutive FIFO entries in the same cycle.
  - Space = DEPTH - count registered at the start of the cycle. A same-cycle pop does NOT free space for a push.
  - Slots beyond the available space are dropped, highest slot first. Each dropped slot sets overflow and increments drop_cnt, which holds at 0xFFFF.
  - ret_cnt increments by the number of accepted slots.
- Order check:
  - Applies to every valid slot, accepted or dropped, in slot order.
  - The first valid slot after reset loads expected = order+1 and is not checked.
  - A mismatch sets order_err, then expected resyncs to order+1.
  - Within a cycle, slot 1 is checked against slot 0's order+1.
  - 64-bit arithmetic wraps.
- Dequeue:
  - out_valid = FIFO non-empty; out_rec = head entry.
  - The entry pops when out_valid && out_ready.
  - Latency: a record written in cycle N appears on out_rec no earlier than N+1, so there is no input-to-output combinational path.
  - out_rec stays stable while out_valid && !out_ready.
- Full/empty:
  - Push into full: dropped as above.
  - Pop from empty: no effect.
  - Simultaneous push and pop at count=DEPTH: the push is dropped and the pop proceeds.
- Pointers are log2(DEPTH)+1 bits with natural wrap.
- Sticky flags clear only on reset.

Decomposition:
- Package rvvi_trace_pkg holds:
  - typedef rvvi_rec_t: order[63:0], insn, pc_rdata, pc_wdata, trap, halt, mode[1:0], x_valid, x_idx[4:0], x_data.
  - Constants NUM_REGS=32 and DROP_MAX=16'hFFFF.
- Sub-module rvvi_trace_fifo:
  - Parameterised on entry type, DEPTH and write ports (RETIRE).
  - Inputs: wr_en vector with compacted data, rd_en.
  - Outputs: count, head.
- The top level holds record build, compaction, order checker and counters.

Test Plan:
- Single retire: slot0 valid, order=5, x_wb=0x0000_0400, x_wdata[10]=0xDEAD_BEEF, out_ready=1 -> next cycle out_valid=1, out_rec.order=5, x_valid=1, x_idx=10, x_data=0xDEADBEEF; ret_cnt=1.
- Dual retire with compaction and order check: cycle A slot1-only order=7; cycle B slots0/1 order=8,9 -> records 7,8,9 come out in order and order_err=0. Then a slot with order=11 -> order_err=1, and the next 12 produces no further error.
- Backpressure/overflow: DEPTH=16, out_ready=0, 9 cycles of dual retire -> 16 accepted, overflow=1, drop_cnt=2, ret_cnt=16, out_rec holds order of the first record. Release out_ready -> 16 records drain in order.
- Writeback rules: x_wb=0x1 (x0 only) -> x_valid=0 and no error. x_wb=0x0000_0006 -> x_idx=1 and multi_wb_err=1.
- Reset mid-stream: FIFO holding 5 entries and sticky flags set, reset for 1 cycle -> next cycle out_valid=0, all flags/counters 0. The first post-reset order=1000 raises no order_err.
- Full with simultaneous pop: count=16, out_ready=1, one valid slot -> slot dropped (drop_cnt+1), count becomes 15.

Source files
------------

// File: rtl/rvvi_trace_pkg.sv
// Shared record type and helpers for the RVVI trace collector.
// Record fields are fixed at 32-bit XLEN/ILEN; the top-level parameters must match.
package rvvi_trace_pkg;

    localparam int          REC_XLEN = 32;
    localparam int          REC_ILEN = 32;
    localparam int          NUM_REGS = 32;
    localparam logic [15:0] DROP_MAX = 16'hFFFF;

    typedef struct packed {
        logic [63:0]         order;
        logic [REC_ILEN-1:0] insn;
        logic [REC_XLEN-1:0] pc_rdata;
        logic [REC_XLEN-1:0] pc_wdata;
        logic                trap;
        logic                halt;
        logic [1:0]          mode;
        logic                x_valid;
        logic [4:0]          x_idx;
        logic [REC_XLEN-1:0] x_data;
    } rvvi_rec_t;

    // Lowest written GPR index, x0 excluded; 0 when nothing is written.
    function automatic logic [4:0] lowest_gpr(input logic [NUM_REGS-1:0] wb);
        logic [4:0] idx;
        idx = '0;
        for (int i = NUM_REGS - 1; i >= 1; i--) begin
            if (wb[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    function automatic logic multi_gpr(input logic [NUM_REGS-1:0] wb);
        logic [NUM_REGS-1:0] v;
        v = {wb[NUM_REGS-1:1], 1'b0};
        return (v & (v - NUM_REGS'(1))) != '0;
    endfunction

endpackage

// File: rtl/rvvi_trace_fifo.sv
// Multi-write, single-read FIFO. Write ports must be compacted: wr_en is a
// prefix of ones and the caller never pushes more than DEPTH - count entries.
module rvvi_trace_fifo #(
    parameter type T        = logic,
    parameter int  DEPTH    = 16,
    parameter int  WR_PORTS = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WR_PORTS-1:0]        wr_en,
    input  T                           wr_data [WR_PORTS],
    input  logic                       rd_en,
    output logic [$clog2(DEPTH):0]     count,
    output T                           head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T               r_mem [DEPTH];
    logic [CW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_rd_ptr;
    logic [CW-1:0]  w_n_push;
    logic           w_pop;

    always_comb begin
        w_n_push = '0;
        for (int i = 0; i < WR_PORTS; i++) begin
            w_n_push = w_n_push + CW'(wr_en[i]);
        end
    end

    assign count = r_wr_ptr - r_rd_ptr;
    assign w_pop = rd_en && (count != '0);
    assign head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + w_n_push;
            if (w_pop) r_rd_ptr <= r_rd_ptr + CW'(1);
        end
    end

    // Storage is not reset; the read side is gated by count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WR_PORTS; i++) begin
            if (wr_en[i]) r_mem[AW'(r_wr_ptr + CW'(i))] <= wr_data[i];
        end
    end

endmodule

// File: rtl/rvvi_trace_collector.sv
// RVVI trace reader: builds compact retirement records per slot, checks order
// continuity and GPR writeback rules, buffers records and drains them valid/ready.
module rvvi_trace_collector
    import rvvi_trace_pkg::*;
#(
    parameter int RETIRE = 2,
    parameter int XLEN   = 32,
    parameter int ILEN   = 32,
    parameter int DEPTH  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [RETIRE-1:0]               in_valid,
    input  logic [RETIRE*64-1:0]            in_order,
    input  logic [RETIRE*ILEN-1:0]          in_insn,
    input  logic [RETIRE-1:0]               in_trap,
    input  logic [RETIRE-1:0]               in_halt,
    input  logic [RETIRE*2-1:0]             in_mode,
    input  logic [RETIRE*XLEN-1:0]          in_pc_rdata,
    input  logic [RETIRE*XLEN-1:0]          in_pc_wdata,
    input  logic [RETIRE*NUM_REGS-1:0]      in_x_wb,
    input  logic [RETIRE*NUM_REGS*XLEN-1:0] in_x_wdata,
    output logic                            out_valid,
    input  logic                            out_ready,
    output rvvi_rec_t                       out_rec,
    output logic                            overflow,
    output logic                            order_err,
    output logic                            multi_wb_err,
    output logic [15:0]                     drop_cnt,
    output logic [31:0]                     ret_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int NW = $clog2(RETIRE + 1);

    rvvi_rec_t          w_rec [RETIRE];
    logic [RETIRE-1:0]  w_multi;

    for (genvar gi = 0; gi < RETIRE; gi++) begin : g_slot
        logic [NUM_REGS-1:0] w_wb;
        logic [4:0]          w_idx;
        logic                w_xv;
        rvvi_rec_t           w_slot_rec;

        assign w_wb        = in_x_wb[gi*NUM_REGS +: NUM_REGS];
        assign w_idx       = lowest_gpr(w_wb);
        assign w_xv        = |w_wb[NUM_REGS-1:1];
        assign w_multi[gi] = multi_gpr(w_wb);

        always_comb begin
            w_slot_rec          = '0;
            w_slot_rec.order    = in_order[gi*64 +: 64];
            w_slot_rec.insn     = in_insn[gi*ILEN +: ILEN];
            w_slot_rec.pc_rdata = in_pc_rdata[gi*XLEN +: XLEN];
            w_slot_rec.pc_wdata = in_pc_wdata[gi*XLEN +: XLEN];
            w_slot_rec.trap     = in_trap[gi];
            w_slot_rec.halt     = in_halt[gi];
            w_slot_rec.mode     = in_mode[gi*2 +: 2];
            w_slot_rec.x_valid  = w_xv;
            w_slot_rec.x_idx    = w_idx;
            if (w_xv) w_slot_rec.x_data = in_x_wdata[(gi*NUM_REGS + int'(w_idx))*XLEN +: XLEN];
        end

        assign w_rec[gi] = w_slot_rec;
    end

    // Compaction: space is taken from the registered count, so a same-cycle pop
    // never makes room; later slots are the ones that lose out.
    logic [CW-1:0]      w_count;
    logic [CW-1:0]      w_space;
    logic [RETIRE-1:0]  w_wr_en;
    rvvi_rec_t          w_wr_data [RETIRE];
    logic [NW-1:0]      w_n_acc;
    logic [NW-1:0]      w_n_drop;
    int                 w_k;

    assign w_space = CW'(DEPTH) - w_count;

    always_comb begin
        w_wr_en  = '0;
        w_n_drop = '0;
        w_k      = 0;
        for (int i = 0; i < RETIRE; i++) w_wr_data[i] = '0;
        for (int i = 0; i < RETIRE; i++) begin
            if (in_valid[i]) begin
                if (w_k < int'(w_space)) begin
                    w_wr_en[w_k]   = 1'b1;
                    w_wr_data[w_k] = w_rec[i];
                    w_k            = w_k + 1;
                end else begin
                    w_n_drop = w_n_drop + NW'(1);
                end
            end
        end
        w_n_acc = NW'(w_k);
    end

    // Order continuity walks slots in order, dropped ones included.
    logic [63:0] r_exp;
    logic        r_exp_vld;
    logic [63:0] w_exp_next;
    logic        w_exp_vld_next;
    logic        w_order_mis;

    always_comb begin
        w_exp_next     = r_exp;
        w_exp_vld_next = r_exp_vld;
        w_order_mis    = 1'b0;
        for (int i = 0; i < RETIRE; i++) begin
            if (in_valid[i]) begin
                if (w_exp_vld_next && (w_rec[i].order != w_exp_next)) w_order_mis = 1'b1;
                w_exp_next     = w_rec[i].order + 64'd1;
                w_exp_vld_next = 1'b1;
            end
        end
    end

    logic        r_overflow;
    logic        r_order_err;
    logic        r_multi_wb_err;
    logic [15:0] r_drop_cnt;
    logic [31:0] r_ret_cnt;
    logic [16:0] w_drop_sum;

    assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_n_drop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_exp          <= '0;
            r_exp_vld      <= 1'b0;
            r_overflow     <= 1'b0;
            r_order_err    <= 1'b0;
            r_multi_wb_err <= 1'b0;
            r_drop_cnt     <= '0;
            r_ret_cnt      <= '0;
        end else begin
            r_exp     <= w_exp_next;
            r_exp_vld <= w_exp_vld_next;
            if (w_order_mis) r_order_err <= 1'b1;
            if (|(w_multi & in_valid)) r_multi_wb_err <= 1'b1;
            if (w_n_drop != '0) r_overflow <= 1'b1;
            r_drop_cnt <= w_drop_sum[16] ? DROP_MAX : w_drop_sum[15:0];
            r_ret_cnt  <= r_ret_cnt + 32'(w_n_acc);
        end
    end

    rvvi_rec_t w_head;

    rvvi_trace_fifo #(
        .T        (rvvi_rec_t),
        .DEPTH    (DEPTH),
        .WR_PORTS (RETIRE)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_wr_en),
        .wr_data (w_wr_data),
        .rd_en   (out_ready),
        .count   (w_count),
        .head    (w_head)
    );

    assign out_valid    = (w_count != '0);
    assign out_rec      = out_valid ? w_head : '0;
    assign overflow     = r_overflow;
    assign order_err    = r_order_err;
    assign multi_wb_err = r_multi_wb_err;
    assign drop_cnt     = r_drop_cnt;
    assign ret_cnt      = r_ret_cnt;

endmodule

// File: tb/tb_rvvi_trace_collector.sv
// Directed bench for rvvi_trace_collector: inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_rvvi_trace_collector;
    import rvvi_trace_pkg::*;

    localparam int RETIRE = 2;
    localparam int XLEN   = 32;
    localparam int ILEN   = 32;
    localparam int DEPTH  = 16;

    logic                            clk = 1'b0;
    logic                            reset;
    logic [RETIRE-1:0]               in_valid;
    logic [RETIRE*64-1:0]            in_order;
    logic [RETIRE*ILEN-1:0]          in_insn;
    logic [RETIRE-1:0]               in_trap;
    logic [RETIRE-1:0]               in_halt;
    logic [RETIRE*2-1:0]             in_mode;
    logic [RETIRE*XLEN-1:0]          in_pc_rdata;
    logic [RETIRE*XLEN-1:0]          in_pc_wdata;
    logic [RETIRE*32-1:0]            in_x_wb;
    logic [RETIRE*32*XLEN-1:0]       in_x_wdata;
    logic                            out_valid;
    logic                            out_ready;
    rvvi_rec_t                       out_rec;
    logic                            overflow;
    logic                            order_err;
    logic                            multi_wb_err;
    logic [15:0]                     drop_cnt;
    logic [31:0]                     ret_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    rvvi_trace_collector #(
        .RETIRE (RETIRE), .XLEN (XLEN), .ILEN (ILEN), .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_order     (in_order),
        .in_insn      (in_insn),
        .in_trap      (in_trap),
        .in_halt      (in_halt),
        .in_mode      (in_mode),
        .in_pc_rdata  (in_pc_rdata),
        .in_pc_wdata  (in_pc_wdata),
        .in_x_wb      (in_x_wb),
        .in_x_wdata   (in_x_wdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rec      (out_rec),
        .overflow     (overflow),
        .order_err    (order_err),
        .multi_wb_err (multi_wb_err),
        .drop_cnt     (drop_cnt),
        .ret_cnt      (ret_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        in_valid    = '0;
        in_order    = '0;
        in_insn     = '0;
        in_trap     = '0;
        in_halt     = '0;
        in_mode     = '0;
        in_pc_rdata = '0;
        in_pc_wdata = '0;
        in_x_wb     = '0;
        in_x_wdata  = '0;
    endtask

    task automatic set_slot(input int s, input logic [63:0] order, input logic [31:0] xwb);
        in_valid[s]                = 1'b1;
        in_order[s*64 +: 64]       = order;
        in_insn[s*ILEN +: ILEN]    = 32'h0000_0013;
        in_pc_rdata[s*XLEN +: XLEN] = 32'h8000_0000 + 32'(order[27:0]) * 4;
        in_pc_wdata[s*XLEN +: XLEN] = 32'h8000_0004 + 32'(order[27:0]) * 4;
        in_x_wb[s*32 +: 32]        = xwb;
    endtask

    task automatic set_xdata(input int s, input int r, input logic [31:0] d);
        in_x_wdata[(s*32 + r)*XLEN +: XLEN] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        out_ready = 1'b0;
        reset     = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        set_slot(0, 64'd3, 32'h4);
        out_ready = 1'b1;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        clear_inputs();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_checks++; if (out_rec !== '0) begin n_fail++; $display("FAIL reset_out_rec: got %h want 0", out_rec); end
        n_checks++; if ({overflow, order_err, multi_wb_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {overflow, order_err, multi_wb_err}); end
        n_checks++; if (drop_cnt !== 16'd0 || ret_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_counters: got drop=%0d ret=%0d want 0 0", drop_cnt, ret_cnt); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        set_slot(0, 64'd5, 32'h0000_0400);
        set_xdata(0, 10, 32'hDEAD_BEEF);
        in_trap[0] = 1'b1;
        in_mode[1:0] = 2'b11;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_comb_path: got %0b want 0", out_valid); end
        step();
        clear_inputs();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b want 1", out_valid); end
        n_checks++; if (out_rec.order !== 64'd5) begin n_fail++; $display("FAIL single_order: got %0d want 5", out_rec.order); end
        n_checks++; if (out_rec.x_valid !== 1'b1 || out_rec.x_idx !== 5'd10) begin n_fail++; $display("FAIL single_xidx: got v=%0b idx=%0d want 1 10", out_rec.x_valid, out_rec.x_idx); end
        n_checks++; if (out_rec.x_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_xdata: got %h want deadbeef", out_rec.x_data); end
        n_checks++; if (out_rec.trap !== 1'b1 || out_rec.mode !== 2'b11 || out_rec.pc_rdata !== 32'h8000_0014) begin n_fail++; $display("FAIL single_fields: got trap=%0b mode=%0d pc=%h want 1 3 80000014", out_rec.trap, out_rec.mode, out_rec.pc_rdata); end
        n_checks++; if (ret_cnt !== 32'd1) begin n_fail++; $display("FAIL single_ret_cnt: got %0d want 1", ret_cnt); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %0b want 0", out_valid); end
        $display("test_single done");
    endtask

    task automatic test_dual_order();
        do_reset();
        out_ready = 1'b1;
        set_slot(1, 64'd7, 32'h0);
        step();
        clear_inputs();
        n_checks++; if (out_valid !== 1'b1 || out_rec.order !== 64'd7) begin n_fail++; $display("FAIL dual_rec7: got v=%0b order=%0d want 1 7", out_valid, out_rec.order); end
        set_slot(0, 64'd8, 32'h0);
        set_slot(1, 64'd9, 32'h0);
        step();
        clear_inputs();
        n_checks++; if (out_rec.order !== 64'd8) begin n_fail++; $display("FAIL dual_rec8: got %0d want 8", out_rec.order); end
        step();
        n_checks++; if (out_valid !== 1'b1 || out_rec.order !== 64'd9) begin n_fail++; $display("FAIL dual_rec9: got v=%0b order=%0d want 1 9", out_valid, out_rec.order); end
        step();
        n_checks++; if (out_valid !== 1'b0 || order_err !== 1'b0 || ret_cnt !== 32'd3) begin n_fail++; $display("FAIL dual_end: got v=%0b err=%0b ret=%0d want 0 0 3", out_valid, order_err, ret_cnt); end
        set_slot(0, 64'd11, 32'h0);
        step();
        clear_inputs();
        n_checks++; if (order_err !== 1'b1 || out_rec.order !== 64'd11) begin n_fail++; $display("FAIL dual_gap: got err=%0b order=%0d want 1 11", order_err, out_rec.order); end
        set_slot(0, 64'd12, 32'h0);
        step();
        clear_inputs();
        n_checks++; if (out_rec.order !== 64'd12 || ret_cnt !== 32'd5) begin n_fail++; $display("FAIL dual_resync: got order=%0d ret=%0d want 12 5", out_rec.order, ret_cnt); end
        step();
        $display("test_dual_order done");
    endtask

    task automatic test_overflow();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            clear_inputs();
            set_slot(0, 64'(100 + 2*c), 32'h0);
            set_slot(1, 64'(101 + 2*c), 32'h0);
            step();
        end
        clear_inputs();
        n_checks++; if (overflow !== 1'b1 || drop_cnt !== 16'd2) begin n_fail++; $display("FAIL ovf_drop: got ovf=%0b drop=%0d want 1 2", overflow, drop_cnt); end
        n_checks++; if (ret_cnt !== 32'd16 || order_err !== 1'b0) begin n_fail++; $display("FAIL ovf_ret: got ret=%0d err=%0b want 16 0", ret_cnt, order_err); end
        n_checks++; if (out_valid !== 1'b1 || out_rec.order !== 64'd100) begin n_fail++; $display("FAIL ovf_head_hold: got v=%0b order=%0d want 1 100", out_valid, out_rec.order); end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_rec.order !== 64'(100 + i)) begin n_fail++; $display("FAIL ovf_drain_%0d: got v=%0b order=%0d want 1 %0d", i, out_valid, out_rec.order, 100 + i); end
            step();
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %0b want 0", out_valid); end
        $display("test_overflow done");
    endtask

    task automatic test_full_pop();
        int k;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            clear_inputs();
            set_slot(0, 64'(200 + 2*c), 32'h0);
            set_slot(1, 64'(201 + 2*c), 32'h0);
            step();
        end
        clear_inputs();
        set_slot(0, 64'd216, 32'h0);
        out_ready = 1'b1;
        step();
        clear_inputs();
        n_checks++; if (drop_cnt !== 16'd1 || overflow !== 1'b1 || ret_cnt !== 32'd16) begin n_fail++; $display("FAIL fullpop_drop: got drop=%0d ovf=%0b ret=%0d want 1 1 16", drop_cnt, overflow, ret_cnt); end
        k = 0;
        while (out_valid === 1'b1 && k < 20) begin
            n_checks++; if (out_rec.order !== 64'(201 + k)) begin n_fail++; $display("FAIL fullpop_rec_%0d: got %0d want %0d", k, out_rec.order, 201 + k); end
            k++;
            step();
        end
        n_checks++; if (k != 15) begin n_fail++; $display("FAIL fullpop_count: got %0d records want 15", k); end
        $display("test_full_pop done");
    endtask

    task automatic test_wb_rules();
        do_reset();
        out_ready = 1'b1;
        set_slot(0, 64'd1, 32'h0000_0001);
        in_x_wb[63:32] = 32'hFFFF_FFFF;
        step();
        clear_inputs();
        n_checks++; if (out_rec.x_valid !== 1'b0 || multi_wb_err !== 1'b0) begin n_fail++; $display("FAIL wb_x0_only: got xv=%0b merr=%0b want 0 0", out_rec.x_valid, multi_wb_err); end
        set_slot(0, 64'd2, 32'h0000_0006);
        set_xdata(0, 1, 32'h1111_1111);
        set_xdata(0, 2, 32'h2222_2222);
        step();
        clear_inputs();
        n_checks++; if (out_rec.x_valid !== 1'b1 || out_rec.x_idx !== 5'd1 || out_rec.x_data !== 32'h1111_1111) begin n_fail++; $display("FAIL wb_lowest: got xv=%0b idx=%0d data=%h want 1 1 11111111", out_rec.x_valid, out_rec.x_idx, out_rec.x_data); end
        n_checks++; if (multi_wb_err !== 1'b1) begin n_fail++; $display("FAIL wb_multi_err: got %0b want 1", multi_wb_err); end
        step();
        $display("test_wb_rules done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_slot(0, 64'd50, 32'h0000_0006);
        set_slot(1, 64'd51, 32'h0);
        step();
        clear_inputs();
        set_slot(0, 64'd52, 32'h0);
        set_slot(1, 64'd53, 32'h0);
        step();
        clear_inputs();
        set_slot(0, 64'd60, 32'h0);
        step();
        clear_inputs();
        n_checks++; if (order_err !== 1'b1 || multi_wb_err !== 1'b1 || ret_cnt !== 32'd5 || out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got err=%0b merr=%0b ret=%0d v=%0b want 1 1 5 1", order_err, multi_wb_err, ret_cnt, out_valid); end
        set_slot(0, 64'd61, 32'h0000_0006);
        out_ready = 1'b1;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        clear_inputs();
        n_checks++; if (out_valid !== 1'b0 || out_rec !== '0) begin n_fail++; $display("FAIL mid_out: got v=%0b rec=%h want 0 0", out_valid, out_rec); end
        n_checks++; if ({overflow, order_err, multi_wb_err} !== 3'b000 || drop_cnt !== 16'd0 || ret_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_clear: got flags=%b drop=%0d ret=%0d want 000 0 0", {overflow, order_err, multi_wb_err}, drop_cnt, ret_cnt); end
        set_slot(0, 64'd1000, 32'h0);
        step();
        clear_inputs();
        n_checks++; if (order_err !== 1'b0 || out_rec.order !== 64'd1000 || ret_cnt !== 32'd1) begin n_fail++; $display("FAIL mid_first: got err=%0b order=%0d ret=%0d want 0 1000 1", order_err, out_rec.order, ret_cnt); end
        step();
        $display("test_reset_mid done");
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_dual_order();
        test_overflow();
        test_full_pop();
        test_wb_rules();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
